dmem_cache_ctrl: RTL and testbench
==================================

// Module: dmem_cache_ctrl
// PURPOSE
//  Data-memory responder for the pipelined core's M stage: direct-mapped, write-through,
//  no-write-allocate cache in front of a fixed-latency backing word memory.
//  Read hits return data the same cycle; misses and all stores hold cpu_stall while
//  the backing memory works. The pipeline holds the request stable while stalled.
// PARAMETERS
//  SETS         16    number of cache lines (power of 2)
//  LINE_WORDS   4     32-bit words per line (power of 2)
//  MEM_WORDS    1024  backing memory depth in words (power of 2)
//  MEM_LATENCY  4     cycles per backing-memory word access (>=2)
// PORTS
//  clk        in   1   clock
//  reset      in   1   synchronous, active-high
//  cpu_read   in   1   load request
//  cpu_write  in   1   store request (wins if cpu_read also high)
//  cpu_addr   in   32  byte address; bits [1:0] ignored
//  cpu_wdata  in   32  store data
//  cpu_rdata  out  32  load data; 0 when cpu_hit=0
//  cpu_hit    out  1   read hit this cycle (combinational)
//  cpu_stall  out  1   request not complete this cycle (combinational)
// BEHAVIOUR
//  - Address split: word=addr[2+:log2(LINE_WORDS)], index=next log2(SETS) bits, tag=rest.
//    Backing index = addr[31:2] mod MEM_WORDS (wraps).
//  - FSM IDLE/FILL/WRITE; lat_cnt (MEM_LATENCY-1 down to 0); word_cnt for refill.
//  - cpu_hit = IDLE & cpu_read & !cpu_write & valid[index] & tag match.
//  - IDLE, read hit: cpu_stall=0, cpu_rdata=line word, stay IDLE.
//  - IDLE, read miss: cpu_stall=1 -> FILL, word_cnt=0, lat_cnt=MEM_LATENCY-1, valid[index] cleared.
//  - FILL: stall=1; at lat_cnt==0 write backing word (line base+word_cnt) into data array,
//    word_cnt++, reload lat_cnt; after last word set tag+valid -> IDLE. Next cycle hits.
//    Total stall = 1 + LINE_WORDS*MEM_LATENCY cycles (17 at defaults).
//  - IDLE, write: stall=1; on hit update cache word at this edge (miss: no allocate);
//    capture addr/data -> WRITE, lat_cnt=MEM_LATENCY-1.
//  - WRITE: stall=1 while lat_cnt!=0; at lat_cnt==0 stall=0, backing word written, -> IDLE.
//    Store stall = exactly MEM_LATENCY cycles.
//  - No request in IDLE: stall=0, hit=0, rdata=0.
//  - Reset (any state, mid-FILL/WRITE): IDLE, all valid=0, counters=0, outputs 0 next cycle;
//    an in-flight store is dropped; backing memory contents are not reset.
// CONFIGURATION
//  DCACHE_STATS_EN defined: adds out ports stat_hits[31:0], stat_misses[31:0], reset to 0;
//   stat_hits +1 per IDLE read-hit cycle, stat_misses +1 per IDLE->FILL; both wrap.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  dcache_pkg: FSM state enum, field-width localparams (WORD_W, IDX_W, TAG_W), addr-split functions.
//  Sub-module dmem_backing: MEM_WORDS x 32 array, combinational read port, sync write port.
//  Tag/valid/data arrays and FSM in dmem_cache_ctrl.
// TESTING
//  1 reset, read 0x40 (mem[16]=0xA5A5A5A5) -> stall 17 cycles, then hit=1 rdata=0xA5A5A5A5.
//  2 read 0x44 after 1 -> hit same cycle, stall=0, rdata=mem[17]; stat_hits=2 (STATS_EN).
//  3 write 0x44 data 0x12345678 (hit) -> stall 4 cycles; read 0x44 hits 0x12345678, mem[17] updated.
//  4 write miss 0x400 data 0xDEAD -> stall 4, mem[256]=0xDEAD, read 0x400 then misses (no allocate).
//  5 read 0x440 conflicting with 0x40 (same index) -> refill evicts; read 0x40 misses again.
//  6 reset asserted mid-FILL -> next cycle IDLE, stall=0, hit=0; read 0x40 misses again.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types, geometry and address-split helpers for the M-stage data cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dcache_pkg;

    localparam int SETS        = 16;
    localparam int LINE_WORDS  = 4;
    localparam int MEM_WORDS   = 1024;
    localparam int MEM_LATENCY = 4;

    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 32 - 2 - WORD_W - IDX_W;
    localparam int MEM_AW = $clog2(MEM_WORDS);
    localparam int LAT_W  = $clog2(MEM_LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // Word offset within a line.
    function automatic logic [WORD_W-1:0] addr_word(input logic [31:0] addr);
        return addr[2 +: WORD_W];
    endfunction

    // Cache set index.
    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
        return addr[2 + WORD_W +: IDX_W];
    endfunction

    // Tag: everything above the index.
    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
        return addr[31 -: TAG_W];
    endfunction

    // Backing-memory word index; upper address bits wrap.
    function automatic logic [MEM_AW-1:0] addr_mem(input logic [31:0] addr);
        return addr[2 +: MEM_AW];
    endfunction

endpackage

// File: rtl/dmem_cache_ctrl_if.sv
// CPU-side load/store request bundle between the M stage and the data cache.
// Latency: n/a (wires only).
// Backpressure: cache asserts cpu_stall; the core holds the request stable meanwhile.
interface dmem_cache_ctrl_if;

    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_hit;
    logic        cpu_stall;

    modport master (
        output cpu_read, cpu_write, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_hit, cpu_stall
    );

    modport slave (
        input  cpu_read, cpu_write, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_hit, cpu_stall
    );

endinterface

// File: rtl/dmem_backing.sv
// Backing word memory behind the data cache; contents are never reset.
// Latency: combinational read, write lands at the clock edge.
// Backpressure: none; access timing is modelled by the cache controller.
module dmem_backing #(
    parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    // Single synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache for the core's M stage.
// Latency: read hit same cycle; read miss stalls 1+LINE_WORDS*MEM_LATENCY; store stalls MEM_LATENCY.
// Backpressure: cpu_stall held while busy. Define DCACHE_STATS_EN to add hit/miss counters.
module dmem_cache_ctrl
    import dcache_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    dmem_cache_ctrl_if.slave   cpu
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]        stat_hits,
    output logic [31:0]        stat_misses
`endif
);

    state_t             state, state_nxt;
    logic [LAT_W-1:0]   lat_cnt, lat_nxt;
    logic [WORD_W-1:0]  word_cnt, word_nxt;

    logic [SETS-1:0]    valid;
    logic [TAG_W-1:0]   tag_arr  [SETS];
    logic [31:0]        data_arr [SETS*LINE_WORDS];

    logic [31:0]        req_addr;
    logic [31:0]        req_wdata;

    logic [IDX_W-1:0]   cur_idx;
    logic [WORD_W-1:0]  cur_word;
    logic [TAG_W-1:0]   cur_tag;
    logic               lookup_hit;

    logic               hit;
    logic               stall;
    logic [31:0]        rdata;
    logic               start_fill;
    logic               fill_we;
    logic               fill_done;
    logic               store_hit_we;
    logic               capture;
    logic               mem_we;

    logic [MEM_AW-1:0]  fill_maddr;
    logic [MEM_AW-1:0]  store_maddr;
    logic [31:0]        mem_rdata;
    logic               unused_addr_bits;

    assign cur_idx    = addr_idx(cpu.cpu_addr);
    assign cur_word   = addr_word(cpu.cpu_addr);
    assign cur_tag    = addr_tag(cpu.cpu_addr);
    assign lookup_hit = valid[cur_idx] && (tag_arr[cur_idx] == cur_tag);

    // Refill walks the captured line from word 0; store goes to the captured word.
    assign fill_maddr  = {req_addr[2 + WORD_W +: MEM_AW - WORD_W], word_cnt};
    assign store_maddr = addr_mem(req_addr);

    // Byte offset is ignored throughout.
    assign unused_addr_bits = ^{req_addr[1:0], cpu.cpu_addr[1:0]};

    dmem_backing #(
        .WORDS (MEM_WORDS)
    ) u_backing (
        .clk   (clk),
        .we    (mem_we),
        .waddr (store_maddr),
        .wdata (req_wdata),
        .raddr (fill_maddr),
        .rdata (mem_rdata)
    );

    // Next-state and CPU-facing outputs; a store wins over a simultaneous load.
    always_comb begin
        state_nxt    = state;
        lat_nxt      = lat_cnt;
        word_nxt     = word_cnt;
        hit          = 1'b0;
        stall        = 1'b0;
        rdata        = '0;
        start_fill   = 1'b0;
        fill_we      = 1'b0;
        fill_done    = 1'b0;
        store_hit_we = 1'b0;
        capture      = 1'b0;
        mem_we       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cpu.cpu_write) begin
                    stall        = 1'b1;
                    store_hit_we = lookup_hit;
                    capture      = 1'b1;
                    lat_nxt      = LAT_W'(MEM_LATENCY - 1);
                    state_nxt    = ST_WRITE;
                end else if (cpu.cpu_read) begin
                    if (lookup_hit) begin
                        hit   = 1'b1;
                        rdata = data_arr[{cur_idx, cur_word}];
                    end else begin
                        stall      = 1'b1;
                        start_fill = 1'b1;
                        capture    = 1'b1;
                        word_nxt   = '0;
                        lat_nxt    = LAT_W'(MEM_LATENCY - 1);
                        state_nxt  = ST_FILL;
                    end
                end
            end

            ST_FILL: begin
                stall = 1'b1;
                if (lat_cnt == '0) begin
                    fill_we  = 1'b1;
                    lat_nxt  = LAT_W'(MEM_LATENCY - 1);
                    word_nxt = word_cnt + WORD_W'(1);
                    if (word_cnt == WORD_W'(LINE_WORDS - 1)) begin
                        fill_done = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    lat_nxt = lat_cnt - LAT_W'(1);
                end
            end

            ST_WRITE: begin
                if (lat_cnt == '0) begin
                    mem_we    = !reset;
                    state_nxt = ST_IDLE;
                end else begin
                    stall   = 1'b1;
                    lat_nxt = lat_cnt - LAT_W'(1);
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign cpu.cpu_hit   = hit;
    assign cpu.cpu_stall = stall;
    assign cpu.cpu_rdata = rdata;

    // Control state, counters and line valid bits; reset abandons any refill or store.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            lat_cnt  <= '0;
            word_cnt <= '0;
            valid    <= '0;
        end else begin
            state    <= state_nxt;
            lat_cnt  <= lat_nxt;
            word_cnt <= word_nxt;
            if (start_fill) begin
                valid[cur_idx] <= 1'b0;
            end
            if (fill_done) begin
                valid[addr_idx(req_addr)] <= 1'b1;
            end
        end
    end

    // Request capture plus tag/data array writes from refill and store hits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (capture) begin
                req_addr  <= cpu.cpu_addr;
                req_wdata <= cpu.cpu_wdata;
            end
            if (fill_we) begin
                data_arr[{addr_idx(req_addr), word_cnt}] <= mem_rdata;
            end else if (store_hit_we) begin
                data_arr[{cur_idx, cur_word}] <= cpu.cpu_wdata;
            end
            if (fill_done) begin
                tag_arr[addr_idx(req_addr)] <= addr_tag(req_addr);
            end
        end
    end

`ifdef DCACHE_STATS_EN
    // Free-running hit/miss event counters; both wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else begin
            if (hit) begin
                stat_hits <= stat_hits + 32'd1;
            end
            if (start_fill) begin
                stat_misses <= stat_misses + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_cache_ctrl.sv
// Self-checking bench for dmem_cache_ctrl: backing-memory model plus read-data scoreboard.
// Latency: checks stall-cycle counts for hits, refills and stores.
// Backpressure: bench holds each request stable until cpu_stall drops.
module tb_dmem_cache_ctrl;
    import dcache_pkg::*;

    logic clk = 1'b0;
    logic reset;

    dmem_cache_ctrl_if cpu ();

`ifdef DCACHE_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    dmem_cache_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .cpu         (cpu)
`ifdef DCACHE_STATS_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
`endif
    );

    always #5 clk = ~clk;

    localparam int FILL_STALL = 1 + LINE_WORDS * MEM_LATENCY;
    localparam int BUDGET     = 200;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl [MEM_WORDS];
    logic [31:0] exp_q [$];
    int          exp_hits = 0;
    int          exp_misses = 0;

    // Called at posedge+1; leaves the bus idle at posedge+1 after the reset edge.
    task automatic do_reset();
        reset = 1'b1;
        cpu.cpu_read  = 1'b0;
        cpu.cpu_write = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic check_idle(input string name);
        #1;
        checks++;
        if (cpu.cpu_stall !== 1'b0 || cpu.cpu_hit !== 1'b0 || cpu.cpu_rdata !== 32'd0) begin
            errors++;
            $display("FAIL %s: stall=%b hit=%b rdata=%h, want 0/0/00000000",
                     name, cpu.cpu_stall, cpu.cpu_hit, cpu.cpu_rdata);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input int exp_stall, input string name);
        int          stalls;
        logic [31:0] exp;
        exp_q.push_back(mdl[addr[2 +: MEM_AW]]);
        cpu.cpu_addr  = addr;
        cpu.cpu_read  = 1'b1;
        cpu.cpu_write = 1'b0;
        #1;
        if (exp_stall > 0) begin
            checks++;
            if (cpu.cpu_hit !== 1'b0 || cpu.cpu_rdata !== 32'd0) begin
                errors++;
                $display("FAIL %s miss_cycle: hit=%b rdata=%h, want 0/00000000",
                         name, cpu.cpu_hit, cpu.cpu_rdata);
            end
        end
        stalls = 0;
        while (cpu.cpu_stall === 1'b1 && stalls < BUDGET) begin
            @(posedge clk);
            #1;
            stalls++;
        end
        checks++;
        if (stalls != exp_stall) begin
            errors++;
            $display("FAIL %s stall: got %0d cycles, want %0d", name, stalls, exp_stall);
        end
        exp = exp_q.pop_front();
        checks++;
        if (cpu.cpu_hit !== 1'b1 || cpu.cpu_rdata !== exp) begin
            errors++;
            $display("FAIL %s data: hit=%b rdata=%h, want 1/%h", name, cpu.cpu_hit, cpu.cpu_rdata, exp);
        end
        exp_hits++;
        if (exp_stall > 0) exp_misses++;
        @(posedge clk);
        #1;
        cpu.cpu_read = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic also_read, input string name);
        int stalls;
        cpu.cpu_addr  = addr;
        cpu.cpu_wdata = data;
        cpu.cpu_write = 1'b1;
        cpu.cpu_read  = also_read;
        #1;
        checks++;
        if (cpu.cpu_hit !== 1'b0 || cpu.cpu_stall !== 1'b1) begin
            errors++;
            $display("FAIL %s first_cycle: hit=%b stall=%b, want 0/1", name, cpu.cpu_hit, cpu.cpu_stall);
        end
        stalls = 0;
        while (cpu.cpu_stall === 1'b1 && stalls < BUDGET) begin
            @(posedge clk);
            #1;
            stalls++;
        end
        checks++;
        if (stalls != MEM_LATENCY) begin
            errors++;
            $display("FAIL %s stall: got %0d cycles, want %0d", name, stalls, MEM_LATENCY);
        end
        mdl[addr[2 +: MEM_AW]] = data;
        @(posedge clk);
        #1;
        cpu.cpu_write = 1'b0;
        cpu.cpu_read  = 1'b0;
    endtask

`ifdef DCACHE_STATS_EN
    task automatic check_stats(input string name);
        checks++;
        if (stat_hits !== 32'(exp_hits) || stat_misses !== 32'(exp_misses)) begin
            errors++;
            $display("FAIL %s stats: hits=%0d misses=%0d, want %0d/%0d",
                     name, stat_hits, stat_misses, exp_hits, exp_misses);
        end
    endtask
`endif

    task automatic test_reset();
        cpu.cpu_read  = 1'b0;
        cpu.cpu_write = 1'b0;
        cpu.cpu_addr  = 32'h40;
        cpu.cpu_wdata = 32'd0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle("reset_outputs");
`ifdef DCACHE_STATS_EN
        check_stats("reset");
`endif
    endtask

    // Fill lines 0x40, 0x440 and 0x400 through write misses (no allocate).
    task automatic test_preload();
        logic [31:0] bases [3];
        bases[0] = 32'h40;
        bases[1] = 32'h440;
        bases[2] = 32'h400;
        for (int b = 0; b < 3; b++) begin
            for (int w = 0; w < LINE_WORDS; w++) begin
                logic [31:0] a;
                a = bases[b] + 32'(4 * w);
                do_write(a, (b == 0 && w == 0) ? 32'hA5A5A5A5 : (32'hC0DE0000 | a), 1'b0, "preload");
            end
        end
    endtask

    task automatic test_miss_fill();
        do_reset();
        do_read(32'h40, FILL_STALL, "miss_0x40");
    endtask

    task automatic test_hit();
        do_read(32'h44, 0, "hit_0x44");
`ifdef DCACHE_STATS_EN
        check_stats("after_hit");
`endif
    endtask

    task automatic test_store_hit();
        do_write(32'h44, 32'h12345678, 1'b0, "store_hit_0x44");
        do_read(32'h44, 0, "reload_0x44");
    endtask

    task automatic test_store_miss();
        do_write(32'h400, 32'h0000DEAD, 1'b0, "store_miss_0x400");
        do_read(32'h400, FILL_STALL, "no_allocate_0x400");
        do_read(32'h400, 0, "hit_0x400");
    endtask

    task automatic test_conflict();
        do_read(32'h440, FILL_STALL, "evict_0x440");
        do_read(32'h40, FILL_STALL, "refill_0x40");
        do_read(32'h44, 0, "backing_0x44");
    endtask

    task automatic test_back_to_back();
        do_read(32'h48, 0, "b2b_0x48");
        do_read(32'h4C, 0, "b2b_0x4C");
        do_read(32'h40, 0, "b2b_0x40");
        check_idle("idle_no_request");
    endtask

    task automatic test_write_wins();
        do_write(32'h48, 32'hBEEF0048, 1'b1, "read_and_write_0x48");
        do_read(32'h48, 0, "after_rw_0x48");
    endtask

    task automatic test_wrap();
        do_read(32'h1040, FILL_STALL, "alias_0x1040");
        do_read(32'h40, FILL_STALL, "after_alias_0x40");
    endtask

    task automatic test_reset_mid_fill();
        cpu.cpu_addr = 32'h440;
        cpu.cpu_read = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        do_reset();
        check_idle("reset_mid_fill");
`ifdef DCACHE_STATS_EN
        check_stats("reset_mid_fill");
`endif
        do_read(32'h40, FILL_STALL, "post_reset_0x40");
    endtask

    task automatic test_reset_mid_write();
        do_read(32'h400, FILL_STALL, "prime_0x400");
        cpu.cpu_addr  = 32'h400;
        cpu.cpu_wdata = 32'h55555555;
        cpu.cpu_write = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        check_idle("reset_mid_write");
        do_read(32'h400, FILL_STALL, "dropped_store_0x400");
    endtask

    initial begin
        test_reset();
        test_preload();
        test_miss_fill();
        test_hit();
        test_store_hit();
        test_store_miss();
        test_conflict();
        test_back_to_back();
        test_write_wins();
        test_wrap();
        test_reset_mid_fill();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
